// File: rtl/serial_tx.sv
// serial_tx: byte-wide to single-wire serial transmitter.
// Frame = start bit (0), DATA_BITS data bits LSB first, optional even-parity
// bit, one stop bit (1). The line idles high. The byte input uses a
// valid/ready handshake.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the even-parity bit).
// out_tx is registered from the current state, so it trails the state
// register by one clock. The start bit therefore appears one cycle after
// the accept edge, and every bit still lasts exactly CLKS_PER_BIT cycles.

module serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_tx,
  output logic                 out_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  state_t                 state_r;
  state_t                 state_s;
  logic [BAUD_W-1:0]      baud_r;
  logic [BIT_W-1:0]       bit_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   tx_r;
  logic                   tx_s;
  logic                   ready_r;
  logic                   accept_s;
  logic                   baud_last_s;
  logic                   bit_last_s;

`ifdef SERIAL_TX_PARITY_EN
  logic                   parity_r;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  assign accept_s    = in_valid && ready_r;
  assign baud_last_s = (baud_r == BAUD_LAST);
  assign bit_last_s  = (bit_r == BIT_LAST);

  assign in_ready = ready_r;
  assign out_busy = ~ready_r;
  assign out_tx   = tx_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: every non-idle state advances at the end of its bit time.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      ST_START: begin
        if (baud_last_s) state_s = ST_DATA;
        else             state_s = ST_START;
      end
      ST_DATA: begin
        if (baud_last_s && bit_last_s) begin
`ifdef SERIAL_TX_PARITY_EN
          state_s = ST_PARITY;
`else
          state_s = ST_STOP;
`endif
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last_s) state_s = ST_STOP;
        else             state_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (baud_last_s) state_s = ST_IDLE;
        else             state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake ready mirrors "next state is IDLE", so it equals state_r==IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= (state_s == ST_IDLE);
    end
  end

  // Baud counter: 0..CLKS_PER_BIT-1 in any active state, wraps at bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_r <= '0;
    end else if ((state_r == ST_IDLE) || baud_last_s) begin
      baud_r <= '0;
    end else begin
      baud_r <= baud_r + BAUD_W'(1);
    end
  end

  // Bit counter: indexes the data bit being sent, only meaningful in DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_r <= '0;
    end else if (state_r != ST_DATA) begin
      bit_r <= '0;
    end else if (baud_last_s) begin
      bit_r <= bit_last_s ? '0 : (bit_r + BIT_W'(1));
    end else begin
      bit_r <= bit_r;
    end
  end

  // Shift register: loaded on accept, shifted right at each data-bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
    end else if (accept_s) begin
      shift_r <= in_data;
    end else if ((state_r == ST_DATA) && baud_last_s) begin
      shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity of the accepted byte, captured alongside the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (accept_s) begin
      parity_r <= even_parity(in_data);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Line level for the current state.
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      ST_IDLE:   tx_s = 1'b1;
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_r[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_s = parity_r;
`endif
      ST_STOP:   tx_s = 1'b1;
      default:   tx_s = 1'b1;
    endcase
  end

  // Registered serial output; reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r <= 1'b1;
    end else begin
      tx_r <= tx_s;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx.
// Main instance uses CLKS_PER_BIT=4, DATA_BITS=8; a second instance uses
// CLKS_PER_BIT=1. Inputs change and outputs are sampled on the falling edge.
// Build with SERIAL_TX_PARITY_EN defined to exercise the parity bit.

module tb_serial_tx;

  localparam int CPB = 4;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
  // Frames listed as {stop, parity, data, start}; bit 0 goes out first.
  localparam logic [10:0] F_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [10:0] F_07 = {1'b1, 1'b1, 8'h07, 1'b0};
  localparam logic [10:0] F_00 = {1'b1, 1'b0, 8'h00, 1'b0};
  localparam logic [10:0] F_FF = {1'b1, 1'b0, 8'hFF, 1'b0};
  localparam logic [10:0] F_3C = {1'b1, 1'b0, 8'h3C, 1'b0};
  localparam logic [10:0] F_81 = {1'b1, 1'b0, 8'h81, 1'b0};
`else
  localparam int NB = 10;
  // Frames listed as {unused, stop, data, start}; bit 0 goes out first.
  localparam logic [10:0] F_A5 = {1'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [10:0] F_07 = {1'b0, 1'b1, 8'h07, 1'b0};
  localparam logic [10:0] F_00 = {1'b0, 1'b1, 8'h00, 1'b0};
  localparam logic [10:0] F_FF = {1'b0, 1'b1, 8'hFF, 1'b0};
  localparam logic [10:0] F_3C = {1'b0, 1'b1, 8'h3C, 1'b0};
  localparam logic [10:0] F_81 = {1'b0, 1'b1, 8'h81, 1'b0};
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_tx;
  logic       out_busy;
  logic [7:0] in_data1;
  logic       in_valid1;
  logic       in_ready1;
  logic       out_tx1;
  logic       out_busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_tx(out_tx), .out_busy(out_busy)
  );

  serial_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_tx(out_tx1), .out_busy(out_busy1)
  );

  // Offer a byte at a falling edge, let it be accepted, then check every cycle
  // of the frame on the main instance.
  task automatic play_frame(input string name, input logic [7:0] data,
                            input logic [10:0] exp, input logic [7:0] next_data,
                            input bit keep_valid);
    logic exp_rdy;
    in_data  = data;
    in_valid = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before got %b want 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_data = next_data;
    if (!keep_valid) in_valid = 1'b0;
    tests++;
    if (out_tx !== 1'b1 || in_ready !== 1'b0 || out_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s accept_cycle got tx=%b rdy=%b busy=%b want tx=1 rdy=0 busy=1",
               name, out_tx, in_ready, out_busy);
    end
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge clk);
      exp_rdy = (k == NB * CPB - 1);
      tests++;
      if (out_tx !== exp[k / CPB]) begin
        fails++;
        $display("FAIL %s tx k=%0d got %b want %b", name, k, out_tx, exp[k / CPB]);
      end
      tests++;
      if (in_ready !== exp_rdy || out_busy !== ~exp_rdy) begin
        fails++;
        $display("FAIL %s ready k=%0d got rdy=%b busy=%b want rdy=%b",
                 name, k, in_ready, out_busy, exp_rdy);
      end
    end
  endtask

  // Idle after reset: line high, ready, not busy for 20 cycles.
  task automatic test_reset;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (out_tx !== 1'b1 || in_ready !== 1'b1 || out_busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle i=%0d got tx=%b rdy=%b busy=%b want 1 1 0",
                 i, out_tx, in_ready, out_busy);
      end
    end
  endtask

  // Single frames: 0xA5 and 0x07 (parity 0 and 1 when parity is enabled).
  task automatic test_frame;
    play_frame("frame_a5", 8'hA5, F_A5, 8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    play_frame("frame_07", 8'h07, F_07, 8'hF0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Valid held high: 0x00 then 0xFF with a single idle cycle between frames.
  task automatic test_back_to_back;
    play_frame("b2b_00", 8'h00, F_00, 8'hFF, 1'b1);
    play_frame("b2b_ff", 8'hFF, F_FF, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Reset mid-frame during a low data bit, then a clean 0x3C frame.
  task automatic test_reset_mid_frame;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    tests++;
    if (out_tx !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_pre got tx=%b rdy=%b want tx=0 rdy=0", out_tx, in_ready);
    end
    in_data  = 8'h3C;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_tx !== 1'b1 || in_ready !== 1'b1 || out_busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async got tx=%b rdy=%b busy=%b want 1 1 0",
               out_tx, in_ready, out_busy);
    end
    #1 rst_n = 1'b1;
    play_frame("after_reset_3c", 8'h3C, F_3C, 8'hC3, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // One clock per bit on the second instance: 0x81.
  task automatic test_fast_bits;
    logic exp_rdy;
    in_data1  = 8'h81;
    in_valid1 = 1'b1;
    tests++;
    if (in_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL fast_ready_before got %b want 1", in_ready1);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = 8'h00;
    tests++;
    if (out_tx1 !== 1'b1 || in_ready1 !== 1'b0) begin
      fails++;
      $display("FAIL fast_accept got tx=%b rdy=%b want tx=1 rdy=0", out_tx1, in_ready1);
    end
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      exp_rdy = (k == NB - 1);
      tests++;
      if (out_tx1 !== F_81[k] || in_ready1 !== exp_rdy || out_busy1 !== ~exp_rdy) begin
        fails++;
        $display("FAIL fast_bit k=%0d got tx=%b rdy=%b want tx=%b rdy=%b",
                 k, out_tx1, in_ready1, F_81[k], exp_rdy);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (out_tx1 !== 1'b1 || in_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL fast_idle got tx=%b rdy=%b want 1 1", out_tx1, in_ready1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_data1  = 8'h00;
    in_valid1 = 1'b0;
    #12 rst_n = 1'b1;
    test_reset();
    test_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_fast_bits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
